grid_io_bank_cfg: RTL and testbench

GRID_IO_BANK_CFG -- requirements
Module: grid_io_bank_cfg

---
 rtl/grid_io_bank_cfg.sv | 130 +++++++++++++
 tb/tb_grid_io_bank_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_bank_cfg.sv
// Serially configured IO bank: a shift chain feeds a shadow register that drives the pads.
// Define GRID_IO_CFG_PARITY_EN to append an even-parity bit to each frame.
module grid_io_bank_cfg #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  input  logic              ccff_shift_en,
  input  logic              ccff_commit,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] pin_outpad,
  output logic [NUM_IO-1:0] pin_inpad,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int FW = 2 * NUM_IO;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int L  = FW + 1;
`else
  localparam int L  = FW;
`endif
  localparam int CW = $clog2(L);

  localparam logic [0:0] UNCFG  = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [L-1:0]  chain_r;
  logic [FW-1:0] shadow_r;
  logic [CW-1:0] cnt_r;
  logic [0:0]    state_r;
  logic          cfg_valid_r;
  logic          cfg_err_r;

  logic commit_req_s;
  logic frame_ok_s;
  logic accept_s;
  logic reject_s;
  logic enabled_s;

`ifdef GRID_IO_CFG_PARITY_EN
  function automatic logic frame_parity(input logic [L-1:0] frame);
    return ^frame;
  endfunction
`endif

  // Commit qualification; a commit coinciding with a shift is silently dropped.
  always_comb begin
    commit_req_s = ccff_commit & ~ccff_shift_en;
`ifdef GRID_IO_CFG_PARITY_EN
    frame_ok_s   = (cnt_r == {CW{1'b0}}) && (frame_parity(chain_r) == 1'b0);
`else
    frame_ok_s   = (cnt_r == {CW{1'b0}});
`endif
    accept_s     = commit_req_s & frame_ok_s;
    reject_s     = commit_req_s & ~frame_ok_s;
  end

  // Shift chain and frame bit counter.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain_r <= {L{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (ccff_shift_en) begin
      chain_r <= {chain_r[L-2:0], ccff_head};
      if (cnt_r == CW'(L - 1)) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      chain_r <= chain_r;
      cnt_r   <= cnt_r;
    end
  end

  // Shadow register and configuration state; only reset leaves ACTIVE.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow_r    <= {FW{1'b0}};
      state_r     <= UNCFG;
      cfg_valid_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        shadow_r    <= chain_r[FW-1:0];
        cfg_valid_r <= 1'b1;
      end else begin
        shadow_r    <= shadow_r;
        cfg_valid_r <= cfg_valid_r;
      end
      cfg_err_r <= cfg_err_r | reject_s;
      case (state_r)
        UNCFG:   state_r <= accept_s ? ACTIVE : UNCFG;
        ACTIVE:  state_r <= ACTIVE;
        default: state_r <= UNCFG;
      endcase
    end
  end

  // Pad muxing straight from the shadow so in-flight shifts never disturb the pads.
  always_comb begin
    enabled_s                        = IO_ISOL_N & (state_r == ACTIVE);
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = {NUM_IO{1'b1}};
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = {NUM_IO{1'b0}};
    pin_inpad                        = {NUM_IO{1'b0}};
    for (int i = 0; i < NUM_IO; i++) begin
      if (enabled_s) begin
        gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = shadow_r[2*i];
        if (shadow_r[2*i]) begin
          pin_inpad[i] = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i] ^ shadow_r[2*i+1];
        end else begin
          gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[i] = pin_outpad[i];
        end
      end else begin
        gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[i] = 1'b1;
      end
    end
  end

  assign ccff_tail = chain_r[L-1];
  assign cfg_valid = cfg_valid_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Scoreboard bench for grid_io_bank_cfg (NUM_IO=4); honours GRID_IO_CFG_PARITY_EN.
module tb_grid_io_bank_cfg;

  localparam int NUM_IO = 4;
  localparam int FW = 2 * NUM_IO;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int L = FW + 1;
`else
  localparam int L = FW;
`endif

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b0;
  logic              IO_ISOL_N = 1'b0;
  logic              ccff_head = 1'b0;
  logic              ccff_shift_en = 1'b0;
  logic              ccff_commit = 1'b0;
  logic [NUM_IO-1:0] pad_in = '0;
  logic [NUM_IO-1:0] pad_out;
  logic [NUM_IO-1:0] pad_dir;
  logic [NUM_IO-1:0] pin_outpad = '0;
  logic [NUM_IO-1:0] pin_inpad;
  logic              ccff_tail;
  logic              cfg_valid;
  logic              cfg_err;

  grid_io_bank_cfg #(.NUM_IO(NUM_IO)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_head                        (ccff_head),
    .ccff_shift_en                    (ccff_shift_en),
    .ccff_commit                      (ccff_commit),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .pin_outpad                       (pin_outpad),
    .pin_inpad                        (pin_inpad),
    .ccff_tail                        (ccff_tail),
    .cfg_valid                        (cfg_valid),
    .cfg_err                          (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [NUM_IO-1:0] dir;
    logic [NUM_IO-1:0] out;
    logic [NUM_IO-1:0] inpad;
    logic              valid;
    logic              err;
    logic              tail;
  } exp_t;

  exp_t         exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [L-1:0] chain_model = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from state updates.
  always @(negedge prog_clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk({n, ".dir"},   32'(pad_dir),   32'(e.dir));
      chk({n, ".out"},   32'(pad_out),   32'(e.out));
      chk({n, ".inpad"}, 32'(pin_inpad), 32'(e.inpad));
      chk({n, ".valid"}, 32'(cfg_valid), 32'(e.valid));
      chk({n, ".err"},   32'(cfg_err),   32'(e.err));
      chk({n, ".tail"},  32'(ccff_tail), 32'(e.tail));
    end
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic expect_pads(input string nm, input logic [3:0] dir, input logic [3:0] out,
                             input logic [3:0] inpad, input logic valid, input logic err);
    exp_t e;
    e.dir = dir; e.out = out; e.inpad = inpad;
    e.valid = valid; e.err = err; e.tail = chain_model[L-1];
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  function automatic logic [L-1:0] mk_frame(input logic [3:0] dir, input logic [3:0] inv);
    logic [L-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      f[2*i]   = dir[i];
      f[2*i+1] = inv[i];
    end
`ifdef GRID_IO_CFG_PARITY_EN
    f[L-1] = ^f[FW-1:0];
`endif
    return f;
  endfunction

  // Shift f[hi] down to f[lo]; optionally raise commit alongside the final bit.
  task automatic shift_bits(input logic [L-1:0] f, input int hi, input int lo, input logic last_commit);
    for (int k = hi; k >= lo; k--) begin
      ccff_head     = f[k];
      ccff_shift_en = 1'b1;
      ccff_commit   = (k == lo) ? last_commit : 1'b0;
      tick();
      chain_model   = {chain_model[L-2:0], f[k]};
    end
    ccff_shift_en = 1'b0;
    ccff_commit   = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic do_commit();
    ccff_commit = 1'b1;
    tick();
    ccff_commit = 1'b0;
  endtask

  task automatic do_reset(input logic with_shift);
    pReset        = 1'b1;
    ccff_shift_en = with_shift;
    ccff_head     = with_shift;
    tick();
    pReset        = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    chain_model   = '0;
  endtask

  logic [L-1:0] fa, fb, fc, fbad;

  initial begin
    fa = mk_frame(4'b0101, 4'b0001);
    fb = mk_frame(4'b0011, 4'b0010);
    fc = mk_frame(4'b1111, 4'b1111);

    do_reset(1'b0);
    do_reset(1'b0);
    IO_ISOL_N  = 1'b1;
    pin_outpad = 4'b1111;
    pad_in     = 4'b0000;
    expect_pads("reset", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);

    shift_bits(fa, L-1, 0, 1'b0);
    expect_pads("uncfg_shifted", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    do_commit();
    expect_pads("commit_a", 4'b0101, 4'b1010, 4'b0001, 1'b1, 1'b0);
    pad_in = 4'b0101;
    expect_pads("a_in0101", 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b0);

    // Commit together with the final shift: shift happens, commit ignored.
    shift_bits(fc, L-1, 0, 1'b1);
    expect_pads("shift_commit", 4'b0101, 4'b1010, 4'b0100, 1'b1, 1'b0);
    do_commit();
    expect_pads("commit_c", 4'b1111, 4'b0000, 4'b1010, 1'b1, 1'b0);

    shift_bits(fb, L-1, L-5, 1'b0);
    expect_pads("active_shift", 4'b1111, 4'b0000, 4'b1010, 1'b1, 1'b0);
    do_commit();
    expect_pads("partial_reject", 4'b1111, 4'b0000, 4'b1010, 1'b1, 1'b1);
    shift_bits(fb, L-6, 0, 1'b0);
    do_commit();
    expect_pads("commit_b", 4'b0011, 4'b1100, 4'b0011, 1'b1, 1'b1);
    pin_outpad = 4'b0110;
    expect_pads("b_outpad0110", 4'b0011, 4'b0100, 4'b0011, 1'b1, 1'b1);

    IO_ISOL_N = 1'b0;
    expect_pads("isolated", 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1);
    IO_ISOL_N = 1'b1;
    expect_pads("deisolated", 4'b0011, 4'b0100, 4'b0011, 1'b1, 1'b1);

`ifdef GRID_IO_CFG_PARITY_EN
    do_reset(1'b0);
    expect_pads("par_reset", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    fbad = fb;
    fbad[L-1] = ~fb[L-1];
    shift_bits(fbad, L-1, 0, 1'b0);
    do_commit();
    expect_pads("par_reject", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
    shift_bits(fb, L-1, 0, 1'b0);
    do_commit();
    expect_pads("par_accept", 4'b0011, 4'b0100, 4'b0011, 1'b1, 1'b1);
`else
    fbad = '0;
`endif

    // Reset part-way through a frame, with shift requested on the reset edge.
    shift_bits(fa, L-1, L-4, 1'b0);
    do_reset(1'b1);
    expect_pads("midframe_reset", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    shift_bits(fa, L-1, 0, 1'b0);
    do_commit();
    expect_pads("after_reset_a", 4'b0101, 4'b0010, 4'b0100, 1'b1, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
